// File: rtl/ucie_stack_rx_flit_buffer_if.sv
// Flit, credit-return and control signals between the mux RX demux, the per-stack
// receive buffer and the protocol layer.
interface ucie_stack_rx_flit_buffer_if #(
  parameter int unsigned FLIT_WIDTH = 256
);
  logic [FLIT_WIDTH-1:0] in_flit;
  logic                  in_valid;
  logic                  in_ready;
  logic [FLIT_WIDTH-1:0] out_flit;
  logic                  out_valid;
  logic                  out_ready;
  logic                  credit_return_valid;
  logic [7:0]            credit_return_count;
  logic                  credit_return_ack;
  logic                  flush;
  logic [7:0]            fill_level;
  logic                  overflow_err;
  logic                  err_clear;

  modport master (
    output in_flit, in_valid, out_ready, credit_return_ack, flush, err_clear,
    input  in_ready, out_flit, out_valid, credit_return_valid, credit_return_count,
           fill_level, overflow_err
  );

  modport slave (
    input  in_flit, in_valid, out_ready, credit_return_ack, flush, err_clear,
    output in_ready, out_flit, out_valid, credit_return_valid, credit_return_count,
           fill_level, overflow_err
  );
endinterface

// File: rtl/ucie_stack_rx_flit_buffer.sv
// Per-stack RX flit buffer: FWFT circular store, sticky overflow flag and batched
// flow-control credit return to the remote transmitter.
module ucie_stack_rx_flit_buffer #(
  parameter int unsigned FLIT_WIDTH   = 256,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CREDIT_BATCH = 4,
  parameter int unsigned IDLE_TIMEOUT = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ucie_stack_rx_flit_buffer_if.slave   bus
);
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TMR_W  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int unsigned TMO_M1 = (IDLE_TIMEOUT == 0) ? 0 : IDLE_TIMEOUT - 1;

  typedef enum logic [1:0] {
    CR_IDLE   = 2'd0,
    CR_PEND   = 2'd1,
    CR_RETURN = 2'd2
  } cr_state_e;

  logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_ovf;

  cr_state_e             r_state, w_state_nxt;
  logic [7:0]            r_pending, w_pending_nxt;
  logic [7:0]            r_cr_count, w_cr_count_nxt;
  logic [TMR_W-1:0]      r_timer, w_timer_nxt;

  logic                  w_full, w_empty, w_push, w_pop;
  logic [7:0]            w_credit_in;

  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = bus.in_valid && bus.in_ready;
  assign w_pop       = !w_empty && bus.out_ready && !bus.flush;
  // Flushed entries are freed slots too, so they are credited like pops.
  assign w_credit_in = 8'(w_pop) + (bus.flush ? 8'(r_count) : 8'd0);

  assign bus.in_ready            = !w_full && !bus.flush;
  assign bus.out_valid           = !w_empty;
  assign bus.out_flit            = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.fill_level          = 8'(r_count);
  assign bus.overflow_err        = r_ovf;
  assign bus.credit_return_valid = (r_state == CR_RETURN);
  assign bus.credit_return_count = (r_state == CR_RETURN) ? r_cr_count : 8'd0;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_flit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
      if (bus.err_clear)                r_ovf <= 1'b0;
      else if (bus.in_valid && w_full)  r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CR_IDLE;
      r_pending  <= 8'd0;
      r_cr_count <= 8'd0;
      r_timer    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_cr_count <= w_cr_count_nxt;
      r_timer    <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pending_nxt  = r_pending + w_credit_in;
    w_cr_count_nxt = r_cr_count;
    w_timer_nxt    = r_timer;
    case (r_state)
      CR_IDLE: begin
        if (w_pending_nxt != 8'd0) begin
          w_state_nxt = CR_PEND;
          w_timer_nxt = '0;
        end
      end
      CR_PEND: begin
        w_timer_nxt = r_timer + TMR_W'(1);
        if ((r_pending >= 8'(CREDIT_BATCH)) ||
            ((IDLE_TIMEOUT != 0) && (r_timer == TMR_W'(TMO_M1)))) begin
          w_state_nxt    = CR_RETURN;
          w_cr_count_nxt = r_pending;
        end
      end
      CR_RETURN: begin
        // Credits freed while the return waits for ack stay pending for the next batch.
        if (bus.credit_return_ack) begin
          w_pending_nxt  = r_pending - r_cr_count + w_credit_in;
          w_cr_count_nxt = 8'd0;
          if (w_pending_nxt != 8'd0) begin
            w_state_nxt = CR_PEND;
            w_timer_nxt = '0;
          end else begin
            w_state_nxt = CR_IDLE;
          end
        end
      end
      default: w_state_nxt = CR_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ucie_stack_rx_flit_buffer.sv
// Directed bench for ucie_stack_rx_flit_buffer: vector table for fill/overflow/batch
// return plus sequences for timeout, streaming, flush, withheld ack and async reset.
module tb_ucie_stack_rx_flit_buffer;
  localparam int unsigned FW = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ucie_stack_rx_flit_buffer_if #(.FLIT_WIDTH(FW)) bus ();

  ucie_stack_rx_flit_buffer #(
    .FLIT_WIDTH(FW), .DEPTH(16), .CREDIT_BATCH(4), .IDLE_TIMEOUT(32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       iv;
    logic [7:0] fl;
    logic       ordy;
    logic       fls;
    logic       ack;
    logic       clr;
    logic       e_ird;
    logic       e_ov;
    logic [7:0] e_fl;
    logic [7:0] e_fill;
    logic       e_crv;
    logic [7:0] e_crc;
    logic       e_ovf;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic ird, input logic ov,
                          input logic [7:0] fl, input logic [7:0] fill, input logic crv,
                          input logic [7:0] crc, input logic ovf);
    chk({tag, ".in_ready"},  256'(bus.in_ready),            256'(ird));
    chk({tag, ".out_valid"}, 256'(bus.out_valid),           256'(ov));
    chk({tag, ".out_flit"},  bus.out_flit,                  256'(fl));
    chk({tag, ".fill"},      256'(bus.fill_level),          256'(fill));
    chk({tag, ".cr_valid"},  256'(bus.credit_return_valid), 256'(crv));
    chk({tag, ".cr_count"},  256'(bus.credit_return_count), 256'(crc));
    chk({tag, ".ovf"},       256'(bus.overflow_err),        256'(ovf));
  endtask

  task automatic set_idle();
    bus.in_valid          = 1'b0;
    bus.in_flit           = '0;
    bus.out_ready         = 1'b0;
    bus.flush             = 1'b0;
    bus.credit_return_ack = 1'b0;
    bus.err_clear         = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] v);
    bus.in_valid = 1'b1;
    bus.in_flit  = 256'(v);
    tick();
    set_idle();
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    tick();
    set_idle();
  endtask

  // Ticks until credit_return_valid rises; returns the edge count or -1 on timeout.
  task automatic wait_return(output int edges);
    edges = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.credit_return_valid) begin
        edges = k;
        break;
      end
    end
  endtask

  initial begin
    int         edges;
    int         rets;
    int         seen;
    logic [7:0] e;

    tbl[0]  = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'd16, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'd16, 1'b0, 8'd0, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'd16, 1'b0, 8'd0, 1'b0};
    tbl[3]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'd16, 1'b0, 8'd0, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 8'd15, 1'b0, 8'd0, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 8'd14, 1'b0, 8'd0, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 8'd13, 1'b0, 8'd0, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 8'd12, 1'b0, 8'd0, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 8'd12, 1'b1, 8'd4, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 8'd12, 1'b1, 8'd4, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 8'd12, 1'b0, 8'd0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 8'd12, 1'b0, 8'd0, 1'b0};

    // Reset values, during and after reset
    set_idle();
    #3;
    chk_outs("rst_low", 1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 8'd0, 1'b0);
    do_reset();
    #1;
    chk_outs("rst_rel", 1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 8'd0, 1'b0);

    // Fill to 15, then table: 16th push, overflow, clear, batch return of 4
    for (int i = 1; i <= 15; i++) push(8'(i));
    #1;
    chk("t1.fill15", 256'(bus.fill_level), 256'(8'd15));
    chk("t1.head",   bus.out_flit,         256'(8'h01));
    for (int i = 0; i < 12; i++) begin
      bus.in_valid          = tbl[i].iv;
      bus.in_flit           = 256'(tbl[i].fl);
      bus.out_ready         = tbl[i].ordy;
      bus.flush             = tbl[i].fls;
      bus.credit_return_ack = tbl[i].ack;
      bus.err_clear         = tbl[i].clr;
      tick();
      set_idle();
      #1;
      chk_outs($sformatf("vec%0d", i), tbl[i].e_ird, tbl[i].e_ov, tbl[i].e_fl,
               tbl[i].e_fill, tbl[i].e_crv, tbl[i].e_crc, tbl[i].e_ovf);
    end
    // Drain: 0x05..0x10 in order, dropped 0x11/0x12 never appear
    for (int i = 0; i < 12; i++) begin
      e = 8'(5 + i);
      chk($sformatf("t1.drain%0d", i), bus.out_flit, 256'(e));
      pop();
    end
    #1;
    chk("t1.empty_valid", 256'(bus.out_valid), 256'(1'b0));
    chk("t1.empty_flit",  bus.out_flit,        256'(8'h00));

    // Single pop then idle: timeout return of 1 after 32 edges
    do_reset();
    push(8'h30);
    push(8'h31);
    pop();
    wait_return(edges);
    chk("t3.timeout_edges", 256'(edges), 256'(32));
    chk("t3.count", 256'(bus.credit_return_count), 256'(8'd1));
    bus.credit_return_ack = 1'b1;
    tick();
    set_idle();
    chk("t3.ack_valid", 256'(bus.credit_return_valid), 256'(1'b0));
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.credit_return_valid) seen++;
    end
    chk("t3.no_more_returns", 256'(seen), 256'(0));

    // Streaming at count=8 with ack tied high
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
    rets = 0;
    bus.credit_return_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_flit   = 256'(8'(8'h28 + i));
      bus.out_ready = 1'b1;
      #1;
      e = 8'(8'h20 + i);
      chk($sformatf("t4.head%0d", i), bus.out_flit, 256'(e));
      chk($sformatf("t4.fill%0d", i), 256'(bus.fill_level), 256'(8'd8));
      if (bus.credit_return_valid) begin
        chk($sformatf("t4.crc%0d", i), 256'(bus.credit_return_count), 256'(8'd4));
        rets++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.credit_return_valid) begin
        chk($sformatf("t4.tail_crc%0d", i), 256'(bus.credit_return_count), 256'(8'd4));
        rets++;
      end
      @(posedge clk);
      #1;
    end
    set_idle();
    chk("t4.returns", 256'(rets), 256'(5));
    chk("t4.final_head", bus.out_flit, 256'(8'h34));

    // Flush at count=5 with a same-cycle pop attempt
    do_reset();
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("t5.in_ready_flush", 256'(bus.in_ready), 256'(1'b0));
    tick();
    set_idle();
    #1;
    chk_outs("t5.post_flush", 1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 8'd0, 1'b0);
    tick();
    chk("t5.cr_valid", 256'(bus.credit_return_valid), 256'(1'b1));
    chk("t5.cr_count", 256'(bus.credit_return_count), 256'(8'd5));
    bus.credit_return_ack = 1'b1;
    tick();
    set_idle();
    chk("t5.acked", 256'(bus.credit_return_valid), 256'(1'b0));
    push(8'h60);
    chk("t5.refill_head", bus.out_flit, 256'(8'h60));

    // Return of 4 with ack withheld across 3 pops, then residual 3 and async reset
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
    for (int i = 0; i < 4; i++) pop();
    tick();
    chk("t6.cr_valid", 256'(bus.credit_return_valid), 256'(1'b1));
    for (int i = 0; i < 3; i++) begin
      pop();
      chk($sformatf("t6.hold%0d", i), 256'(bus.credit_return_count), 256'(8'd4));
    end
    bus.credit_return_ack = 1'b1;
    tick();
    set_idle();
    chk("t6.ack_valid", 256'(bus.credit_return_valid), 256'(1'b0));
    chk("t6.fill", 256'(bus.fill_level), 256'(8'd1));
    chk("t6.head", bus.out_flit, 256'(8'h47));
    wait_return(edges);
    chk("t6.resid_edges", 256'(edges), 256'(32));
    chk("t6.resid_count", 256'(bus.credit_return_count), 256'(8'd3));
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("t6.async_rst", 1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 8'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
